// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage WISC pipeline, with per-stage sequence
// tags, valid bits, a memory-wait watchdog FSM and saturating statistics counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_reads_flags,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_sets_flags,
    input  logic [3:0]       ex_rd,
    input  logic             mem_busy,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [TAG_W-1:0] if_tag,
    output logic [TAG_W-1:0] id_tag,
    output logic [TAG_W-1:0] ex_tag,
    output logic [TAG_W-1:0] mem_tag,
    output logic [TAG_W-1:0] wb_tag,
    output logic             id_vld,
    output logic             ex_vld,
    output logic             mem_vld,
    output logic             wb_vld,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             timeout,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    localparam int unsigned WC_W = $clog2(MAX_WAIT + 1);

    state_t          st;
    logic [WC_W-1:0] wait_cnt;

    logic load_use;
    logic flag_haz;
    logic br_flush;
    logic freeze;

    always_comb begin
        load_use = ex_mem_read & ex_reg_write & (ex_rd != 4'd0) &
                   ((id_rs1_used & (id_rs1 == ex_rd)) |
                    (id_rs2_used & (id_rs2 == ex_rd)));
        flag_haz = id_is_branch & id_reads_flags & ex_sets_flags;
        br_flush = id_is_branch & id_branch_taken;
        freeze   = mem_busy | (st == TIMEOUT);
    end

    // A hazard stall suppresses the branch flush: the branch re-evaluates next cycle.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        if (!rst_n) begin
            pc_stall = 1'b0;
        end else if (freeze) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (load_use | flag_haz) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else if (br_flush) begin
            if_id_flush = 1'b1;
        end
    end

    // wait_cnt holds the number of consecutive busy cycles already seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= RUN;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            case (st)
                RUN: begin
                    if (mem_busy) begin
                        st       <= WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                WAIT: begin
                    if (!mem_busy) begin
                        st       <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt >= WC_W'(MAX_WAIT)) begin
                        st      <= TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                TIMEOUT: begin
                    st      <= TIMEOUT;
                    timeout <= 1'b1;
                end
                default: begin
                    st       <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_tag  <= '0;
            id_tag  <= '0;
            ex_tag  <= '0;
            mem_tag <= '0;
            wb_tag  <= '0;
            id_vld  <= 1'b0;
            ex_vld  <= 1'b0;
            mem_vld <= 1'b0;
            wb_vld  <= 1'b0;
        end else begin
            if (!pc_stall) begin
                if_tag <= if_tag + TAG_W'(1);
            end
            if (!if_id_stall) begin
                id_tag <= if_tag;
                id_vld <= ~if_id_flush;
            end
            if (!id_ex_stall) begin
                ex_tag <= id_tag;
                ex_vld <= id_vld & ~id_ex_flush;
            end
            if (!ex_mem_stall) begin
                mem_tag <= ex_tag;
                mem_vld <= ex_vld;
            end
            wb_tag <= mem_tag;
            wb_vld <= mem_vld & ~mem_wb_flush;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((if_id_flush || id_ex_flush) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (wb_vld && (retire_cnt != '1)) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: walks one continuous instruction stream
// through hazards, flushes, memory freezes, the watchdog timeout and tag wrap.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        id_is_branch, id_branch_taken, id_reads_flags;
    logic        ex_mem_read, ex_reg_write, ex_sets_flags;
    logic        mem_busy;
    logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic        if_id_flush, id_ex_flush, mem_wb_flush;
    logic [7:0]  if_tag, id_tag, ex_tag, mem_tag, wb_tag;
    logic        id_vld, ex_vld, mem_vld, wb_vld;
    logic [15:0] stall_cnt, flush_cnt, retire_cnt;
    logic        timeout;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    // ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_wb_flush}
    logic [6:0]  ctl;
    logic [39:0] tags;
    logic [3:0]  vlds;
    assign ctl  = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                   if_id_flush, id_ex_flush, mem_wb_flush};
    assign tags = {if_tag, id_tag, ex_tag, mem_tag, wb_tag};
    assign vlds = {id_vld, ex_vld, mem_vld, wb_vld};

    localparam logic [6:0] CTL_NONE   = 7'b0000000;
    localparam logic [6:0] CTL_HAZ    = 7'b1100010;
    localparam logic [6:0] CTL_FREEZE = 7'b1111001;
    localparam logic [6:0] CTL_BRANCH = 7'b0000100;

    pipeline_hazard_ctrl #(.TAG_W(8), .CNT_W(16), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
        .id_reads_flags(id_reads_flags),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_sets_flags(ex_sets_flags), .ex_rd(ex_rd), .mem_busy(mem_busy),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_flush(mem_wb_flush),
        .if_tag(if_tag), .id_tag(id_tag), .ex_tag(ex_tag),
        .mem_tag(mem_tag), .wb_tag(wb_tag),
        .id_vld(id_vld), .ex_vld(ex_vld), .mem_vld(mem_vld), .wb_vld(wb_vld),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt),
        .timeout(timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 4'd0; id_rs2 = 4'd0; ex_rd = 4'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_is_branch = 1'b0; id_branch_taken = 1'b0; id_reads_flags = 1'b0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_sets_flags = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic set_load_use(input logic [3:0] rd, input logic [3:0] rs1);
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
        id_rs1 = rs1; id_rs1_used = 1'b1;
    endtask

    // Every hazard input active while in reset: outputs stay low and the FSM stays in RUN.
    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        set_load_use(4'd3, 4'd3);
        id_is_branch = 1'b1; id_branch_taken = 1'b1;
        mem_busy = 1'b1;
        #2;
        checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_NONE); end
        tick(); tick();
        checks++; if (state !== 2'd0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_state: got state=%0d timeout=%0d expected 0/0", state, timeout); end
        checks++; if (tags !== 40'h0 || vlds !== 4'h0) begin errors++; $display("FAIL reset_tags: got tags=%h vld=%b expected 0/0", tags, vlds); end
        checks++; if ({stall_cnt, flush_cnt, retire_cnt} !== 48'h0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0/0/0", stall_cnt, flush_cnt, retire_cnt); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    // Tag k-4 sits in WB after edge k; retire_cnt counts WB-valid cycles already completed.
    task automatic test_basic();
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k < 4) begin
                checks++; if (wb_vld !== 1'b0) begin errors++; $display("FAIL basic_fill edge %0d: got wb_vld=%0d expected 0", k, wb_vld); end
            end else begin
                checks++; if (wb_vld !== 1'b1 || wb_tag !== 8'(k - 4)) begin errors++; $display("FAIL basic_wb edge %0d: got vld=%0d tag=%0d expected 1/%0d", k, wb_vld, wb_tag, k - 4); end
            end
            checks++; if (retire_cnt !== 16'((k > 4) ? k - 4 : 0)) begin errors++; $display("FAIL basic_retire edge %0d: got %0d expected %0d", k, retire_cnt, (k > 4) ? k - 4 : 0); end
        end
        checks++; if (tags !== 40'h0908070605 || vlds !== 4'b1111) begin errors++; $display("FAIL basic_tags: got %h/%b expected 0908070605/1111", tags, vlds); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL basic_stall: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        set_load_use(4'd3, 4'd3);
        #1;
        checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL lu_ctl: got %b expected %b", ctl, CTL_HAZ); end
        tick();
        checks++; if (tags !== 40'h0908080706 || vlds !== 4'b1011) begin errors++; $display("FAIL lu_bubble: got %h/%b expected 0908080706/1011", tags, vlds); end
        checks++; if (stall_cnt !== 16'd1 || flush_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got stall=%0d flush=%0d expected 1/1", stall_cnt, flush_cnt); end
        // Matching rs2 that is not read, then a load to R0: neither is a hazard.
        clear_inputs();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd5; id_rs2 = 4'd5;
        #1;
        checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL lu_rs2_unused: got %b expected %b", ctl, CTL_NONE); end
        id_rs2_used = 1'b1;
        #1;
        checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL lu_rs2: got %b expected %b", ctl, CTL_HAZ); end
        clear_inputs();
        set_load_use(4'd0, 4'd0);
        #1;
        checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL lu_r0: got %b expected %b", ctl, CTL_NONE); end
        tick();
        checks++; if (tags !== 40'h0a09080807 || vlds !== 4'b1101 || stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_r0_next: got %h/%b stall=%0d expected 0a09080807/1101/1", tags, vlds, stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch();
        id_is_branch = 1'b1; id_branch_taken = 1'b1;
        #1;
        checks++; if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL br_ctl: got %b expected %b", ctl, CTL_BRANCH); end
        tick();
        clear_inputs();
        checks++; if (tags !== 40'h0b0a090808 || vlds !== 4'b0110 || flush_cnt !== 16'd2) begin errors++; $display("FAIL br_squash: got %h/%b flush=%0d expected 0b0a090808/0110/2", tags, vlds, flush_cnt); end
        tick(); tick(); tick();
        checks++; if (wb_tag !== 8'h0a || wb_vld !== 1'b0 || retire_cnt !== 16'd10) begin errors++; $display("FAIL br_wb: got tag=%h vld=%0d retire=%0d expected 0a/0/10", wb_tag, wb_vld, retire_cnt); end
        tick();
        checks++; if (tags !== 40'h0f0e0d0c0b || vlds !== 4'b1111 || retire_cnt !== 16'd10) begin errors++; $display("FAIL br_after: got %h/%b retire=%0d expected 0f0e0d0c0b/1111/10", tags, vlds, retire_cnt); end
    endtask

    task automatic test_flag_haz();
        id_is_branch = 1'b1; id_branch_taken = 1'b1; id_reads_flags = 1'b1; ex_sets_flags = 1'b1;
        #1;
        checks++; if (ctl !== CTL_HAZ) begin errors++; $display("FAIL fh_ctl: got %b expected %b", ctl, CTL_HAZ); end
        tick();
        checks++; if (tags !== 40'h0f0e0e0d0c || vlds !== 4'b1011 || stall_cnt !== 16'd2 || flush_cnt !== 16'd3) begin errors++; $display("FAIL fh_stall: got %h/%b stall=%0d flush=%0d expected 0f0e0e0d0c/1011/2/3", tags, vlds, stall_cnt, flush_cnt); end
        ex_sets_flags = 1'b0;
        #1;
        checks++; if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL fh_then_flush: got %b expected %b", ctl, CTL_BRANCH); end
        tick();
        clear_inputs();
        checks++; if (tags !== 40'h100f0e0e0d || vlds !== 4'b0101 || flush_cnt !== 16'd4 || retire_cnt !== 16'd12) begin errors++; $display("FAIL fh_flushed: got %h/%b flush=%0d retire=%0d expected 100f0e0e0d/0101/4/12", tags, vlds, flush_cnt, retire_cnt); end
    endtask

    task automatic test_mem_busy();
        mem_busy = 1'b1;
        set_load_use(4'd3, 4'd3);
        #1;
        checks++; if (ctl !== CTL_FREEZE) begin errors++; $display("FAIL mb_ctl: got %b expected %b", ctl, CTL_FREEZE); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (state !== 2'd1 || tags !== 40'h100f0e0e0e || vlds !== 4'b0100) begin errors++; $display("FAIL mb_hold cycle %0d: got state=%0d %h/%b expected 1/100f0e0e0e/0100", k, state, tags, vlds); end
        end
        clear_inputs();
        #1;
        checks++; if (ctl !== CTL_NONE) begin errors++; $display("FAIL mb_release_ctl: got %b expected %b", ctl, CTL_NONE); end
        tick();
        checks++; if (state !== 2'd0 || tags !== 40'h11100f0e0e || vlds !== 4'b1010) begin errors++; $display("FAIL mb_resume: got state=%0d %h/%b expected 0/11100f0e0e/1010", state, tags, vlds); end
        checks++; if (stall_cnt !== 16'd5 || retire_cnt !== 16'd13) begin errors++; $display("FAIL mb_cnt: got stall=%0d retire=%0d expected 5/13", stall_cnt, retire_cnt); end
    endtask

    // 15 busy cycles is the longest legal wait; the 16th trips the watchdog.
    task automatic test_timeout();
        mem_busy = 1'b1;
        repeat (15) tick();
        checks++; if (state !== 2'd1 || timeout !== 1'b0) begin errors++; $display("FAIL to_limit: got state=%0d timeout=%0d expected 1/0", state, timeout); end
        mem_busy = 1'b0;
        tick();
        checks++; if (state !== 2'd0 || stall_cnt !== 16'd20) begin errors++; $display("FAIL to_legal_exit: got state=%0d stall=%0d expected 0/20", state, stall_cnt); end
        mem_busy = 1'b1;
        repeat (15) tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL to_wait15: got state=%0d expected 1", state); end
        tick();
        checks++; if (state !== 2'd2 || timeout !== 1'b1) begin errors++; $display("FAIL to_trip: got state=%0d timeout=%0d expected 2/1", state, timeout); end
        repeat (4) tick();
        mem_busy = 1'b0;
        #1;
        checks++; if (ctl !== CTL_FREEZE || stall_cnt !== 16'd40) begin errors++; $display("FAIL to_sticky_ctl: got %b stall=%0d expected %b/40", ctl, stall_cnt, CTL_FREEZE); end
        tick();
        checks++; if (state !== 2'd2 || timeout !== 1'b1) begin errors++; $display("FAIL to_sticky: got state=%0d timeout=%0d expected 2/1", state, timeout); end
        rst_n = 1'b0;
        mem_busy = 1'b1;
        #1;
        checks++; if (state !== 2'd0 || timeout !== 1'b0 || ctl !== CTL_NONE || stall_cnt !== 16'd0) begin errors++; $display("FAIL to_reset: got state=%0d timeout=%0d ctl=%b stall=%0d expected 0/0/0/0", state, timeout, ctl, stall_cnt); end
        tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL to_busy_in_reset: got state=%0d expected 0", state); end
        mem_busy = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        repeat (255) tick();
        checks++; if (if_tag !== 8'hff) begin errors++; $display("FAIL wrap_ff: got if_tag=%h expected ff", if_tag); end
        tick();
        checks++; if (if_tag !== 8'h00 || wb_tag !== 8'hfc || wb_vld !== 1'b1 || retire_cnt !== 16'd252) begin errors++; $display("FAIL wrap_00: got if=%h wb=%h vld=%0d retire=%0d expected 00/fc/1/252", if_tag, wb_tag, wb_vld, retire_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_use();
        test_branch();
        test_flag_haz();
        test_mem_busy();
        test_timeout();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
